// File: rtl/hazard_scoreboard.sv
// Issue hazard scoreboard: per-register latency countdowns, data/WAW/
// control/structural stall detection, mispredict flush FSM, stall stats.
// Ports: clk, rst_n (async, active-low)
//   iss_valid/rs1/rs2/rd/lat : instruction offered for issue
//   fwd_en, br_pend, br_mispred, unit_busy : hazard context
//   iss_ready, stall : combinational issue handshake
//   flush, cause : registered flush pulse and stall cause
//   stall_cnt, flush_cnt : saturating statistics
module hazard_scoreboard #(
    parameter int NREG      = 16,
    parameter int LAT_W     = 3,
    parameter int FLUSH_CYC = 2,
    parameter int CNT_W     = 16,
    localparam int RW       = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             iss_valid,
    input  logic [RW-1:0]    iss_rs1,
    input  logic [RW-1:0]    iss_rs2,
    input  logic [RW-1:0]    iss_rd,
    input  logic [LAT_W-1:0] iss_lat,
    input  logic             fwd_en,
    input  logic             br_pend,
    input  logic             br_mispred,
    input  logic             unit_busy,
    output logic             iss_ready,
    output logic             stall,
    output logic             flush,
    output logic [1:0]       cause,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic {S_RUN, S_FLUSH} state_t;

    state_t           state, state_nxt;
    logic [3:0]       tmr, tmr_nxt;
    logic [LAT_W-1:0] sb [NREG];

    logic [LAT_W-1:0] sb_rs1, sb_rs2, sb_rd;
    logic             haz_rs1, haz_rs2, waw;
    logic             ctrl_stall, data_stall, accept;
    logic             flush_nxt;
    logic [1:0]       cause_nxt;

    assign sb_rs1 = sb[iss_rs1];
    assign sb_rs2 = sb[iss_rs2];
    assign sb_rd  = sb[iss_rd];

    // A source due next cycle is covered by the bypass when forwarding is on.
    assign haz_rs1 = (iss_rs1 != '0) && (sb_rs1 != '0)
                   && !((sb_rs1 == LAT_W'(1)) && fwd_en);
    assign haz_rs2 = (iss_rs2 != '0) && (sb_rs2 != '0)
                   && !((sb_rs2 == LAT_W'(1)) && fwd_en);
    // A shorter new write must not land before an older one to the same reg.
    assign waw = (iss_rd != '0) && (iss_lat != '0) && (sb_rd > iss_lat);

    assign ctrl_stall = br_mispred || (state == S_FLUSH) || br_pend;
    assign data_stall = haz_rs1 || haz_rs2 || waw;

    assign iss_ready = !ctrl_stall && !data_stall && !unit_busy;
    assign stall     = iss_valid && !iss_ready;
    assign accept    = iss_valid && iss_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_RUN;
            tmr   <= '0;
        end else begin
            state <= state_nxt;
            tmr   <= tmr_nxt;
        end
    end

    // A mispredict always (re)starts the flush window, even mid-flush.
    always_comb begin
        state_nxt = state;
        tmr_nxt   = tmr;
        if (br_mispred) begin
            state_nxt = S_FLUSH;
            tmr_nxt   = 4'(FLUSH_CYC - 1);
        end else begin
            case (state)
                S_RUN: ;
                S_FLUSH: begin
                    if (tmr == '0) state_nxt = S_RUN;
                    else           tmr_nxt   = tmr - 4'd1;
                end
                default: state_nxt = S_RUN;
            endcase
        end
    end

    always_comb begin
        flush_nxt = br_mispred;
        cause_nxt = 2'd0;
        if (stall) begin
            if (ctrl_stall)      cause_nxt = 2'd1;
            else if (data_stall) cause_nxt = 2'd2;
            else                 cause_nxt = 2'd3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush     <= 1'b0;
            cause     <= 2'd0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            flush <= flush_nxt;
            cause <= cause_nxt;
            if (stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
            if (br_mispred && (flush_cnt != '1))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

    // Flush leaves the countdowns alone: older writes still retire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++)
                sb[r] <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (r == 0)
                    sb[r] <= '0;
                else if (accept && (iss_rd == RW'(r)))
                    sb[r] <= iss_lat;
                else if (sb[r] != '0)
                    sb[r] <= sb[r] - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: a driver queues expected
// responses per cycle, a negedge monitor pops and compares them.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       iss_valid = 1'b0;
    logic [3:0] iss_rs1 = '0, iss_rs2 = '0, iss_rd = '0;
    logic [2:0] iss_lat = '0;
    logic       fwd_en = 1'b0, br_pend = 1'b0;
    logic       br_mispred = 1'b0, unit_busy = 1'b0;
    logic       iss_ready, stall, flush;
    logic [1:0] cause;
    logic [3:0] stall_cnt, flush_cnt;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string      name;
        logic       er;
        logic       es;
        logic       ef;
        logic [1:0] ec;
        logic       cc;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .NREG(16), .LAT_W(3), .FLUSH_CYC(2), .CNT_W(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .iss_valid(iss_valid), .iss_rs1(iss_rs1),
        .iss_rs2(iss_rs2), .iss_rd(iss_rd), .iss_lat(iss_lat),
        .fwd_en(fwd_en), .br_pend(br_pend),
        .br_mispred(br_mispred), .unit_busy(unit_busy),
        .iss_ready(iss_ready), .stall(stall), .flush(flush),
        .cause(cause), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk({e.name, "_rdy"}, int'(iss_ready), int'(e.er));
            chk({e.name, "_stall"}, int'(stall), int'(e.es));
            if (e.cc) begin
                chk({e.name, "_flush"}, int'(flush), int'(e.ef));
                chk({e.name, "_cause"}, int'(cause), int'(e.ec));
            end
        end
    end

    task automatic step(input string nm, input logic er,
                        input logic ef, input logic [1:0] ec,
                        input logic cc);
        exp_t e;
        e.name = nm;
        e.er   = er;
        e.es   = iss_valid && !er;
        e.ef   = ef;
        e.ec   = ec;
        e.cc   = cc;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input string nm, input logic v,
                       input logic [3:0] rs1, input logic [3:0] rs2,
                       input logic [3:0] rd, input logic [2:0] lat,
                       input logic fwd, input logic bp,
                       input logic bm, input logic ub,
                       input logic er, input logic ef,
                       input logic [1:0] ec);
        iss_valid  = v;
        iss_rs1    = rs1;
        iss_rs2    = rs2;
        iss_rd     = rd;
        iss_lat    = lat;
        fwd_en     = fwd;
        br_pend    = bp;
        br_mispred = bm;
        unit_busy  = ub;
        step(nm, er, ef, ec, 1'b1);
    endtask

    task automatic clr_in();
        iss_valid  = 1'b0;
        iss_rs1    = '0;
        iss_rs2    = '0;
        iss_rd     = '0;
        iss_lat    = '0;
        fwd_en     = 1'b0;
        br_pend    = 1'b0;
        br_mispred = 1'b0;
        unit_busy  = 1'b0;
    endtask

    task automatic do_reset(input string nm);
        rst_n = 1'b0;
        clr_in();
        #1;
        chk({nm, "_flush"}, int'(flush), 0);
        chk({nm, "_cause"}, int'(cause), 0);
        chk({nm, "_scnt"}, int'(stall_cnt), 0);
        chk({nm, "_fcnt"}, int'(flush_cnt), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        @(posedge clk);
        #1;
        do_reset("rst0");

        // RAW on rs1, no forwarding: consumer arrives while sb=2
        cyc("a_iss",  1, 0, 0, 5, 3, 0, 0, 0, 0, 1, 0, 0);
        cyc("a_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        cyc("a_st1",  1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("a_st2",  1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2);
        cyc("a_acc",  1, 5, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2);
        cyc("a_done", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        chk("a_scnt", int'(stall_cnt), 2);

        // Same on rs2 with forwarding: one stall only
        do_reset("rst_b");
        cyc("b_iss",  1, 0, 0, 5, 3, 1, 0, 0, 0, 1, 0, 0);
        cyc("b_idle", 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0);
        cyc("b_st1",  1, 0, 5, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        cyc("b_acc",  1, 0, 5, 0, 0, 1, 0, 0, 0, 1, 0, 2);
        cyc("b_done", 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0);
        chk("b_scnt", int'(stall_cnt), 1);

        // Mispredict: three blocked cycles, one flush pulse
        do_reset("rst_c");
        cyc("c_bm",   1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        cyc("c_f1",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        cyc("c_f0",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc("c_run",  1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        cyc("c_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        chk("c_fcnt", int'(flush_cnt), 1);
        chk("c_scnt", int'(stall_cnt), 3);
        // Back-to-back mispredicts: reload timer, re-pulse flush
        cyc("c2_bm",  0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        cyc("c2_bm2", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
        cyc("c2_f1",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc("c2_f0",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("c2_run", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        chk("c2_fcnt", int'(flush_cnt), 3);
        chk("c2_scnt", int'(stall_cnt), 3);

        // Cause priority: control > data > structural
        do_reset("rst_d");
        cyc("d_iss",  1, 0, 0, 3, 7, 0, 0, 0, 0, 1, 0, 0);
        cyc("d_all",  1, 3, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
        cyc("d_dat",  1, 3, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
        cyc("d_str",  1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2);
        cyc("d_clr",  0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3);
        cyc("d_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);

        // WAW until sb[7] <= 1; register 0 never hazards
        do_reset("rst_e");
        cyc("e_iss",  1, 0, 0, 7, 4, 0, 0, 0, 0, 1, 0, 0);
        cyc("e_w4",   1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc("e_w3",   1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 2);
        cyc("e_w2",   1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 2);
        cyc("e_acc",  1, 0, 0, 7, 1, 0, 0, 0, 0, 1, 0, 2);
        cyc("e_rd0",  1, 0, 0, 0, 7, 0, 0, 0, 0, 1, 0, 0);
        cyc("e_rd0b", 1, 0, 0, 0, 3, 0, 0, 0, 0, 1, 0, 0);
        chk("e_scnt", int'(stall_cnt), 3);

        // Stall counter saturation with 4-bit counters
        do_reset("rst_f");
        iss_valid = 1'b1;
        br_pend   = 1'b1;
        for (int i = 0; i < 21; i++)
            step("f_hold", 1'b0, 1'b0, (i == 0) ? 2'd0 : 2'd1, 1'b1);
        chk("f_sat", int'(stall_cnt), 15);
        clr_in();

        // Async reset in the middle of a flush window
        do_reset("rst_g");
        cyc("g_bm",   1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        chk("g_pre_flush", int'(flush), 1);
        chk("g_pre_cause", int'(cause), 1);
        #1;
        rst_n = 1'b0;
        clr_in();
        iss_valid = 1'b1;
        iss_rd    = 4'd5;
        iss_lat   = 3'd2;
        #1;
        chk("g_async_flush", int'(flush), 0);
        chk("g_async_cause", int'(cause), 0);
        chk("g_async_scnt", int'(stall_cnt), 0);
        chk("g_async_fcnt", int'(flush_cnt), 0);
        chk("g_async_rdy", int'(iss_ready), 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc("g_acc",  1, 0, 0, 5, 2, 0, 0, 0, 0, 1, 0, 0);
        cyc("g_raw",  1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("g_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
